// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmit serializer: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   DATA_BITS     data bits per frame (5..8)
//   PARITY        0 = none, 1 = even, 2 = odd
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports:
//   clk       system clock, rising-edge active
//   reset     asynchronous, active-high reset
//   tx_start  send request, only looked at while idle
//   tx_data   parallel word, captured on the accepting edge
//   tx_out    registered serial line, idles high
//   tx_busy   high from the accepting edge until the frame completes
//   tx_done   single-cycle pulse when the last stop bit completes

module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  // Last cycle of the current bit period; every state transition happens here.
  logic bit_end;
  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            shreg    <= tx_data;
            // Parity is taken from the captured word so later tx_data
            // changes cannot disturb the frame in flight.
            par_bit  <= (PARITY == 2) ? ~(^tx_data) : ^tx_data;
            cnt      <= '0;
            idx      <= '0;
            stop_cnt <= 1'b0;
            // Start bit goes out on the accepting edge itself.
            tx_out   <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end) begin
            cnt    <= '0;
            tx_out <= shreg[0];
            state  <= ST_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              if (PARITY != 0) begin
                tx_out <= par_bit;
                state  <= ST_PARITY;
              end else begin
                tx_out <= 1'b1;
                state  <= ST_STOP;
              end
            end else begin
              // shreg[0] is the bit on the line now, so the next one is shreg[1].
              shreg  <= shreg >> 1;
              tx_out <= shreg[1];
              idx    <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            cnt    <= '0;
            tx_out <= 1'b1;
            state  <= ST_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_STOP: begin
          tx_out <= 1'b1;
          if (bit_end) begin
            cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx across parity and stop-bit variants.

module tb_uart_tx;

  localparam int C = 4;

  logic       clk;
  logic       reset;
  logic [3:0] start;
  logic [7:0] din [4];
  wire  [3:0] outs;
  wire  [3:0] busys;
  wire  [3:0] dones;

  int passed = 0;
  int total  = 0;

  // Instance 0: no parity, 1 stop; 1: even; 2: odd; 3: no parity, 2 stop.
  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .tx_start(start[0]), .tx_data(din[0]),
    .tx_out(outs[0]), .tx_busy(busys[0]), .tx_done(dones[0]));
  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .tx_start(start[1]), .tx_data(din[1]),
    .tx_out(outs[1]), .tx_busy(busys[1]), .tx_done(dones[1]));
  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .tx_start(start[2]), .tx_data(din[2]),
    .tx_out(outs[2]), .tx_busy(busys[2]), .tx_done(dones[2]));
  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .tx_start(start[3]), .tx_data(din[3]),
    .tx_out(outs[3]), .tx_busy(busys[3]), .tx_done(dones[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          inst;
    logic [15:0] bits;
    int          nbits;
    int          gap;
  } exp_t;

  exp_t q[$];

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected line as a string of bit symbols, first bit sent first.
  // An empty string means the frame must be abandoned without tx_done.
  task automatic expect_frame(int i, string s, int gap);
    exp_t e;
    e.inst  = i;
    e.bits  = '0;
    e.nbits = s.len();
    e.gap   = gap;
    for (int j = 0; j < s.len(); j++) e.bits[j] = (s[j] == 8'h31);
    q.push_back(e);
  endtask

  // Monitor state
  logic [63:0] line [4];
  int          ncyc [4];
  int          idle [4];
  int          gap_meas [4];
  int          done_cnt [4];
  logic [3:0]  prev_busy;
  logic [3:0]  prev_done;

  task automatic end_frame(int i, logic d);
    exp_t e;
    int   bad;
    if (q.size() == 0) begin
      chk("unexpected_frame", i, -1);
      return;
    end
    e = q.pop_front();
    chk("frame_inst", i, e.inst);
    if (e.nbits == 0) begin
      chk("abort_no_done", int'(d), 0);
    end else begin
      chk("done_at_end", int'(d), 1);
      chk("busy_len", ncyc[i], C * e.nbits);
      bad = 0;
      for (int j = 0; j < ncyc[i] && j < 64; j++)
        if (line[i][j] !== e.bits[j / C]) bad++;
      chk("line_wave", bad, 0);
      if (e.gap >= 0) chk("idle_gap", gap_meas[i], e.gap);
    end
  endtask

  initial begin
    prev_busy = '0;
    prev_done = '0;
    for (int i = 0; i < 4; i++) begin
      line[i] = '0; ncyc[i] = 0; idle[i] = 1000; gap_meas[i] = 0; done_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (dones[i]) begin
          done_cnt[i]++;
          chk("done_width", int'(prev_done[i]), 0);
        end
        if (busys[i]) begin
          if (!prev_busy[i]) begin
            gap_meas[i] = idle[i];
            idle[i]     = 0;
            ncyc[i]     = 0;
          end
          if (ncyc[i] < 64) line[i][ncyc[i]] = outs[i];
          ncyc[i]++;
        end else begin
          if (prev_busy[i]) end_frame(i, dones[i]);
          if (idle[i] < 1000) idle[i]++;
        end
        prev_busy[i] = busys[i];
        prev_done[i] = dones[i];
      end
    end
  end

  // Caller sits just after a rising edge; the request is seen on the next edge.
  task automatic send(int i, logic [7:0] v);
    din[i]   = v;
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(int i);
    int t;
    t = 0;
    while (busys[i] && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (busys[i]) chk("timeout_busy", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out",  int'(outs),  4'hF);
    chk("reset_busy", int'(busys), 0);
    chk("reset_done", int'(dones), 0);
    reset = 1'b0;

    repeat (20) begin
      @(posedge clk); #1;
      chk("idle_hold", int'({outs, busys, dones}), 12'hF00);
    end

    expect_frame(0, "0101001011", -1);
    send(0, 8'hA5);
    wait_idle(0);

    expect_frame(1, "01110000011", -1);
    send(1, 8'h07);
    wait_idle(1);

    expect_frame(2, "01110000001", -1);
    send(2, 8'h07);
    wait_idle(2);

    // Held-high start: second frame follows after exactly one idle cycle.
    expect_frame(3, "00011110011", -1);
    expect_frame(3, "01111111111", 1);
    din[3]   = 8'h3C;
    start[3] = 1'b1;
    @(posedge clk); #1;
    din[3] = 8'hFF;
    for (int t = 0; t < 300 && busys[3]; t++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start[3] = 1'b0;
    wait_idle(3);

    // Start pulse and data change mid-frame must not alter or queue anything.
    expect_frame(0, "0110000111", -1);
    send(0, 8'hC3);
    repeat (9) begin @(posedge clk); #1; end
    din[0]   = 8'h00;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    din[0]   = 8'hFF;
    wait_idle(0);
    repeat (3) begin @(posedge clk); #1; end
    chk("no_queued_frame", int'(busys[0]), 0);

    // Reset in the 13th cycle of a frame.
    expect_frame(0, "", -1);
    send(0, 8'h81);
    repeat (12) @(posedge clk);
    #2;
    chk("pre_reset_line", int'(outs[0]), 0);
    reset = 1'b1;
    #1;
    chk("async_reset_out",  int'(outs[0]),  1);
    chk("async_reset_busy", int'(busys[0]), 0);
    chk("async_reset_done", int'(dones[0]), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    expect_frame(0, "0100000011", -1);
    send(0, 8'h81);
    wait_idle(0);

    repeat (5) begin @(posedge clk); #1; end
    chk("queue_empty", q.size(), 0);
    chk("done_cnt_0", done_cnt[0], 3);
    chk("done_cnt_1", done_cnt[1], 1);
    chk("done_cnt_2", done_cnt[2], 1);
    chk("done_cnt_3", done_cnt[3], 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter serializer for the transmit side of the UART link; it is the counterpart of the receive-path start-bit detection and sampling logic. It accepts one parallel byte per handshake and drives an asynchronous serial frame on `tx_out`: start bit, data LSB first, optional parity, then 1 or 2 stop bits. An internal divider counts clock cycles per bit. The block sits between the UART control FSM, which supplies data and start, and the pad.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal range 5–8.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.

- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `tx_start`  input  1  request to send; sampled only in IDLE.
- `tx_data`  input  DATA_BITS  byte to send; captured on the accepting edge.
- `tx_out`  output  1  serial line, registered; idles high.
- `tx_busy`  output  1  high from the accepting edge until the frame ends.
- `tx_done`  output  1  one-cycle pulse when the final stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx_out` = 1, `tx_busy` = 0.
  - If `tx_start` = 1 at a rising edge:
    - latch `tx_data` into the shift register;
    - compute the parity bit from the latched data: even = XOR of the data bits, odd = its inverse;
    - clear the bit-cycle counter and bit index;
    - go to START, with `tx_out` ← 0 and `tx_busy` ← 1.
- **START**
  - Hold `tx_out` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with `tx_out` ← data bit 0.
- **DATA**
  - Each bit is held `CLKS_PER_BIT` cycles, then the register shifts right and the index increments.
  - After bit `DATA_BITS-1`:
    - go to PARITY if `PARITY` ≠ 0, otherwise go to STOP;
    - `tx_out` ← the parity bit or 1 accordingly.
- **PARITY**
  - Hold the parity bit `CLKS_PER_BIT` cycles, then go to STOP with `tx_out` ← 1.
- **STOP**
  - Hold `tx_out` = 1 for `STOP_BITS × CLKS_PER_BIT` cycles.
  - Then go to IDLE, with `tx_busy` ← 0 and `tx_done` ← 1 for exactly one cycle.
- Counter width is `$clog2(CLKS_PER_BIT)`. It counts 0 to `CLKS_PER_BIT-1` and wraps to 0 on each bit boundary. The stop phase uses a separate stop-bit count.
- `tx_start` while busy: ignored, with no queuing. `tx_data` changes after acceptance: no effect on the frame in flight.
- Held-high `tx_start`: a new frame is accepted on the first edge in IDLE, giving continuous back-to-back frames.
- Reset values (asynchronous, immediate):
  - `tx_out` = 1, `tx_busy` = 0, `tx_done` = 0;
  - state IDLE; counter, index and shift register = 0.
- Reset mid-frame: the line returns high at once, the frame is abandoned, and there is no `tx_done`.

## Timing
- Frame length: F = `CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)` cycles.
- Let the accepting edge be edge k.
- Start bit: `tx_out` falls after edge k and stays low until edge k+C.
- Data bits: bit i is valid from edge k+C·(1+i) for C cycles.
- Frame end: at edge k+F, `tx_busy` falls and `tx_done` rises; `tx_done` falls at edge k+F+1.
- Earliest next accept is edge k+F+1, so back-to-back frames are separated by one idle-high clock cycle.
- Latency from the `tx_start` edge to `tx_out` low is 0 cycles; the output is registered on that same edge.

## Test plan
- Reset, then hold idle 20 cycles with `tx_start` = 0 → `tx_out` = 1, `tx_busy` = 0, `tx_done` = 0 throughout.
- C = 4, no parity, 1 stop, send 8'hA5 → per 4-cycle bit, line reads 0,1,0,1,0,0,1,0,1,1. `tx_busy` is high 40 cycles; `tx_done` pulses once at cycle 40.
- C = 4, even parity, send 8'h07 → parity bit = 1. With odd parity, send 8'h07 → parity bit = 0. Frame length is 44 cycles.
- `STOP_BITS` = 2, `tx_start` held high, send 8'h3C then 8'hFF → two frames; each stop is high 8 cycles; frames are separated by exactly 1 extra idle cycle; `tx_done` pulses twice.
- Pulse `tx_start` again and change `tx_data` during DATA → frame unchanged and no second frame is queued.
- Assert `reset` at cycle 13 of a frame → `tx_out` goes to 1 immediately and `tx_busy` goes to 0, with no `tx_done`. A new `tx_start` after release yields a clean, complete frame.
